// File: rtl/atm_ctrl_param.sv
// atm_ctrl_param: ATM session controller.
//   Takes a card, checks the PIN (card retained after MAX_TRIES wrong PINs),
//   runs inquiry, deposit and withdraw against one registered balance, and caps
//   the total withdrawn per session at WD_LIMIT. An idle waiting state times out
//   after TIMEOUT cycles and ejects the card. Removing the card mid-session
//   aborts to EJECT.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   card_in               level, card present
//   pin_valid / pin       PIN strobe and value
//   op_valid / op_code    operation strobe: 00 inquiry, 01 deposit, 10 withdraw, 11 eject
//   amt_valid / amount    amount strobe and value
//   another_op            sampled in DISPLAY, 1 returns to CHOOSE
//   balance               registered account balance
//   state                 current state encoding
//   err_code              0 none, 1 bad PIN, 2 funds, 3 limit, 4 overflow, 5 timeout, 6 zero amount
//   card_eject, done      one-cycle pulses (registered, asserted the cycle after EJECT/RETAIN)
//   card_retain           sticky until reset
module atm_ctrl_param #(
  parameter int               BAL_W     = 32,
  parameter int               PIN_W     = 4,
  parameter logic [BAL_W-1:0] INIT_BAL  = 32'h000F4240,
  parameter logic [PIN_W-1:0] PIN_CODE  = 4'b1010,
  parameter int               MAX_TRIES = 3,
  parameter logic [BAL_W-1:0] WD_LIMIT  = 32'd50000,
  parameter int               TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             amt_valid,
  input  logic [BAL_W-1:0] amount,
  input  logic             another_op,
  output logic [BAL_W-1:0] balance,
  output logic [3:0]       state,
  output logic [2:0]       err_code,
  output logic             card_eject,
  output logic             card_retain,
  output logic             done
);

  localparam int             TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]     MAX_T  = 3'(MAX_TRIES);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PIN      = 4'd1,
    S_CHOOSE   = 4'd2,
    S_DEPOSIT  = 4'd3,
    S_WITHDRAW = 4'd4,
    S_CHECK    = 4'd5,
    S_UPDATE   = 4'd6,
    S_DISPLAY  = 4'd7,
    S_EJECT    = 4'd8,
    S_RETAIN   = 4'd9
  } state_t;

  state_t           st;
  logic [2:0]       tries;
  logic [BAL_W-1:0] sess_total;
  logic [BAL_W-1:0] amt_q;
  logic             is_wd;
  logic             armed;     // card_in seen low since the last eject
  logic [TW-1:0]    timer;

  logic             waiting;
  logic             strobe;
  logic             timed_out;
  logic             card_lost;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W:0]   wd_sum;

  assign state = st;

  // Only the strobe that belongs to the current state counts.
  always_comb begin
    strobe  = 1'b0;
    waiting = 1'b0;
    case (st)
      S_PIN:                begin strobe = pin_valid; waiting = 1'b1; end
      S_CHOOSE:             begin strobe = op_valid;  waiting = 1'b1; end
      S_DEPOSIT, S_WITHDRAW: begin strobe = amt_valid; waiting = 1'b1; end
      default:              ;
    endcase
  end

  assign timed_out = waiting && !strobe && (timer == T_LAST);
  assign card_lost = !card_in && (st != S_IDLE) && (st != S_EJECT) && (st != S_RETAIN);
  assign dep_sum   = {1'b0, balance} + {1'b0, amt_q};
  assign wd_sum    = {1'b0, sess_total} + {1'b0, amt_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      balance     <= INIT_BAL;
      err_code    <= 3'd0;
      card_eject  <= 1'b0;
      card_retain <= 1'b0;
      done        <= 1'b0;
      tries       <= 3'd0;
      sess_total  <= '0;
      amt_q       <= '0;
      is_wd       <= 1'b0;
      armed       <= 1'b1;
      timer       <= '0;
    end else begin
      card_eject <= 1'b0;
      done       <= 1'b0;

      // Every exit from a waiting state into another waiting state is caused
      // by a strobe, and non-waiting states hold the timer at zero, so this
      // one rule also covers "reset on state change".
      timer <= (waiting && !strobe) ? timer + 1'b1 : '0;

      if (st == S_EJECT) armed <= !card_in;
      else if (!card_in) armed <= 1'b1;

      if (card_lost) begin
        st <= S_EJECT;
      end else begin
        case (st)
          S_IDLE: begin
            if (card_in && armed && !card_retain) begin
              st         <= S_PIN;
              tries      <= 3'd0;
              sess_total <= '0;
              err_code   <= 3'd0;
            end
          end
          S_PIN: begin
            if (pin_valid) begin
              if (pin == PIN_CODE) begin
                st       <= S_CHOOSE;
                err_code <= 3'd0;
              end else begin
                tries    <= tries + 3'd1;
                err_code <= 3'd1;
                if (tries + 3'd1 == MAX_T) st <= S_RETAIN;
              end
            end else if (timed_out) begin
              st       <= S_EJECT;
              err_code <= 3'd5;
            end
          end
          S_CHOOSE: begin
            if (op_valid) begin
              case (op_code)
                2'b00:   st <= S_DISPLAY;
                2'b01:   st <= S_DEPOSIT;
                2'b10:   st <= S_WITHDRAW;
                default: st <= S_EJECT;
              endcase
            end else if (timed_out) begin
              st       <= S_EJECT;
              err_code <= 3'd5;
            end
          end
          S_DEPOSIT, S_WITHDRAW: begin
            if (amt_valid) begin
              amt_q <= amount;
              is_wd <= (st == S_WITHDRAW);
              if (amount == '0) begin
                err_code <= 3'd6;
                st       <= S_DISPLAY;
              end else begin
                st <= S_CHECK;
              end
            end else if (timed_out) begin
              st       <= S_EJECT;
              err_code <= 3'd5;
            end
          end
          S_CHECK: begin
            if (!is_wd) begin
              if (dep_sum[BAL_W]) begin
                err_code <= 3'd4;
                st       <= S_DISPLAY;
              end else begin
                st <= S_UPDATE;
              end
            end else if (amt_q > balance) begin
              err_code <= 3'd2;          // funds failure outranks the limit
              st       <= S_DISPLAY;
            end else if (wd_sum > {1'b0, WD_LIMIT}) begin
              err_code <= 3'd3;
              st       <= S_DISPLAY;
            end else begin
              st <= S_UPDATE;
            end
          end
          S_UPDATE: begin
            if (is_wd) begin
              balance    <= balance - amt_q;
              sess_total <= wd_sum[BAL_W-1:0];
            end else begin
              balance <= dep_sum[BAL_W-1:0];
            end
            err_code <= 3'd0;
            st       <= S_DISPLAY;
          end
          S_DISPLAY: st <= another_op ? S_CHOOSE : S_EJECT;
          S_EJECT: begin
            card_eject <= 1'b1;
            done       <= 1'b1;
            st         <= S_IDLE;
          end
          S_RETAIN: begin
            card_retain <= 1'b1;
            done        <= 1'b1;
            st          <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Bench for atm_ctrl_param: a default-parameter instance (index 0) and an
// INIT_BAL=100 instance (index 1) share every input except card_in, so only
// the instance whose card is inserted runs a session.
module tb_atm_ctrl_param;

  localparam int          TIMEOUT = 1000;
  localparam longint      WDL     = 50000;
  localparam logic [3:0]  PINC    = 4'b1010;
  localparam logic [31:0] BIG0    = 32'd1000000;
  localparam logic [31:0] SMALL0  = 32'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        card_in = 1'b0, card_in_s = 1'b0;
  logic        pin_valid = 1'b0, op_valid = 1'b0, amt_valid = 1'b0, another_op = 1'b0;
  logic [3:0]  pin = '0;
  logic [1:0]  op_code = '0;
  logic [31:0] amount = '0;

  logic [31:0] balance_b, balance_s;
  logic [3:0]  state_b, state_s;
  logic [2:0]  err_b, err_s;
  logic        ej_b, ej_s, ret_b, ret_s, done_b, done_s;

  int checks = 0;
  int failures = 0;

  // Transaction-level account model per instance.
  longint unsigned m_bal[2];
  longint unsigned m_sess[2];
  int              m_err[2];

  always #5 clk = ~clk;

  atm_ctrl_param #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .card_in(card_in),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op_code(op_code),
    .amt_valid(amt_valid), .amount(amount), .another_op(another_op),
    .balance(balance_b), .state(state_b), .err_code(err_b),
    .card_eject(ej_b), .card_retain(ret_b), .done(done_b));

  atm_ctrl_param #(.INIT_BAL(32'd100), .TIMEOUT(TIMEOUT)) dut_s (
    .clk(clk), .reset(reset), .card_in(card_in_s),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op_code(op_code),
    .amt_valid(amt_valid), .amount(amount), .another_op(another_op),
    .balance(balance_s), .state(state_s), .err_code(err_s),
    .card_eject(ej_s), .card_retain(ret_s), .done(done_s));

  function automatic int st_of(input int s);
    return (s == 1) ? int'(state_s) : int'(state_b);
  endfunction
  function automatic longint unsigned bal_of(input int s);
    return (s == 1) ? longint'(balance_s) : longint'(balance_b);
  endfunction
  function automatic int err_of(input int s);
    return (s == 1) ? int'(err_s) : int'(err_b);
  endfunction
  function automatic logic ej_of(input int s);
    return (s == 1) ? ej_s : ej_b;
  endfunction
  function automatic logic done_of(input int s);
    return (s == 1) ? done_s : done_b;
  endfunction
  function automatic logic ret_of(input int s);
    return (s == 1) ? ret_s : ret_b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_card(input int s, input logic v);
    if (s == 1) card_in_s = v;
    else card_in = v;
  endtask

  // Expected outcome of one operation computed from the account rules.
  task automatic model_apply(input int s, input logic [1:0] op, input logic [31:0] a);
    longint unsigned x;
    x = a;
    if (op == 2'b00) return;
    if (x == 0) m_err[s] = 6;
    else if (op == 2'b01) begin
      if (m_bal[s] + x > 64'hFFFF_FFFF) m_err[s] = 4;
      else begin m_bal[s] = m_bal[s] + x; m_err[s] = 0; end
    end else begin
      if (x > m_bal[s]) m_err[s] = 2;
      else if (m_sess[s] + x > WDL) m_err[s] = 3;
      else begin
        m_bal[s]  = m_bal[s] - x;
        m_sess[s] = m_sess[s] + x;
        m_err[s]  = 0;
      end
    end
  endtask

  task automatic do_reset();
    card_in = 0; card_in_s = 0;
    pin_valid = 0; op_valid = 0; amt_valid = 0; another_op = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    m_bal[0] = BIG0; m_bal[1] = SMALL0;
    m_sess[0] = 0; m_sess[1] = 0;
    m_err[0] = 0; m_err[1] = 0;
  endtask

  task automatic session_start(input int s);
    set_card(s, 1);
    tick();
    m_sess[s] = 0; m_err[s] = 0;
    checks++;
    if (st_of(s) !== 1) begin failures++; $display("FAIL start_state: got %0d want 1", st_of(s)); end
  endtask

  task automatic enter_pin(input int s, input logic [3:0] p, input int exp_st, input int exp_err);
    pin_valid = 1; pin = p;
    tick();
    pin_valid = 0;
    checks++;
    if (st_of(s) !== exp_st) begin failures++; $display("FAIL pin_state: got %0d want %0d", st_of(s), exp_st); end
    checks++;
    if (err_of(s) !== exp_err) begin failures++; $display("FAIL pin_err: got %0d want %0d", err_of(s), exp_err); end
    if (exp_st == 2) m_err[s] = 0;
  endtask

  task automatic do_txn(input int s, input logic [1:0] op, input logic [31:0] a);
    int exp_st;
    op_valid = 1; op_code = op;
    tick();
    op_valid = 0;
    exp_st = (op == 2'b00) ? 7 : (op == 2'b01) ? 3 : 4;
    checks++;
    if (st_of(s) !== exp_st) begin failures++; $display("FAIL txn_op_state: got %0d want %0d", st_of(s), exp_st); end
    if (op != 2'b00) begin
      amt_valid = 1; amount = a;
      tick();
      amt_valid = 0;
      model_apply(s, op, a);
      exp_st = (a == 0) ? 7 : 5;
      checks++;
      if (st_of(s) !== exp_st) begin failures++; $display("FAIL txn_amt_state: got %0d want %0d", st_of(s), exp_st); end
      if (a != 0) begin
        tick();
        exp_st = (m_err[s] == 0) ? 6 : 7;
        checks++;
        if (st_of(s) !== exp_st) begin failures++; $display("FAIL txn_check_state: got %0d want %0d", st_of(s), exp_st); end
        if (m_err[s] == 0) begin
          tick();
          checks++;
          if (st_of(s) !== 7) begin failures++; $display("FAIL txn_update_state: got %0d want 7", st_of(s)); end
        end
      end
    end
    checks++;
    if (bal_of(s) !== m_bal[s]) begin failures++; $display("FAIL txn_balance: got %0d want %0d", bal_of(s), m_bal[s]); end
    checks++;
    if (err_of(s) !== m_err[s]) begin failures++; $display("FAIL txn_err: got %0d want %0d", err_of(s), m_err[s]); end
  endtask

  // Leave DISPLAY; with another=0 also walk through EJECT and check the pulses.
  task automatic finish_display(input int s, input logic another);
    another_op = another;
    tick();
    another_op = 0;
    checks++;
    if (st_of(s) !== (another ? 2 : 8)) begin failures++; $display("FAIL display_next: got %0d want %0d", st_of(s), another ? 2 : 8); end
    if (!another) begin
      tick();
      checks++;
      if (st_of(s) !== 0 || ej_of(s) !== 1'b1 || done_of(s) !== 1'b1) begin
        failures++; $display("FAIL eject_pulse: state=%0d eject=%0b done=%0b want 0/1/1", st_of(s), ej_of(s), done_of(s));
      end
      tick();
      checks++;
      if (ej_of(s) !== 1'b0 || done_of(s) !== 1'b0) begin
        failures++; $display("FAIL eject_one_cycle: eject=%0b done=%0b want 0/0", ej_of(s), done_of(s));
      end
    end
  endtask

  task automatic end_card(input int s);
    set_card(s, 0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (st_of(s) !== 0 || err_of(s) !== 0 || ej_of(s) !== 0 || ret_of(s) !== 0 || done_of(s) !== 0) begin
        failures++; $display("FAIL reset_outputs[%0d]: state=%0d err=%0d ej=%0b ret=%0b done=%0b want all 0", s, st_of(s), err_of(s), ej_of(s), ret_of(s), done_of(s));
      end
      checks++;
      if (bal_of(s) !== m_bal[s]) begin failures++; $display("FAIL reset_balance[%0d]: got %0d want %0d", s, bal_of(s), m_bal[s]); end
    end
  endtask

  task automatic test_withdraw_basic();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    do_txn(0, 2'b10, 32'd40000);
    checks++;
    if (balance_b !== 32'd960000) begin failures++; $display("FAIL wd_basic_balance: got %0d want 960000", balance_b); end
    finish_display(0, 1'b0);
    checks++;
    if (err_b !== 3'd0) begin failures++; $display("FAIL wd_basic_err: got %0d want 0", err_b); end
    end_card(0);
  endtask

  task automatic test_limit();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    do_txn(0, 2'b10, 32'd30000);
    finish_display(0, 1'b1);
    do_txn(0, 2'b10, 32'd30000);
    checks++;
    if (err_b !== 3'd3 || balance_b !== 32'd970000) begin
      failures++; $display("FAIL limit: err=%0d bal=%0d want 3/970000", err_b, balance_b);
    end
    finish_display(0, 1'b0);
    end_card(0);
  endtask

  task automatic test_insufficient();
    do_reset();
    session_start(1);
    enter_pin(1, PINC, 2, 0);
    do_txn(1, 2'b10, 32'd200);
    checks++;
    if (err_s !== 3'd2 || balance_s !== 32'd100) begin
      failures++; $display("FAIL insufficient: err=%0d bal=%0d want 2/100", err_s, balance_s);
    end
    finish_display(1, 1'b0);
    end_card(1);
  endtask

  task automatic test_overflow();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    do_txn(0, 2'b01, 32'hFFFF_FFFF);
    checks++;
    if (err_b !== 3'd4 || balance_b !== 32'd1000000) begin
      failures++; $display("FAIL overflow: err=%0d bal=%0d want 4/1000000", err_b, balance_b);
    end
    finish_display(0, 1'b1);
    do_txn(0, 2'b01, 32'd500);
    checks++;
    if (err_b !== 3'd0 || balance_b !== 32'd1000500) begin
      failures++; $display("FAIL deposit: err=%0d bal=%0d want 0/1000500", err_b, balance_b);
    end
    finish_display(0, 1'b0);
    end_card(0);
  endtask

  task automatic test_retain();
    do_reset();
    session_start(0);
    enter_pin(0, 4'b0001, 1, 1);
    enter_pin(0, 4'b0001, 1, 1);
    enter_pin(0, 4'b0001, 9, 1);
    tick();
    checks++;
    if (state_b !== 4'd0 || ret_b !== 1'b1 || done_b !== 1'b1 || ej_b !== 1'b0) begin
      failures++; $display("FAIL retain_pulse: state=%0d ret=%0b done=%0b ej=%0b want 0/1/1/0", state_b, ret_b, done_b, ej_b);
    end
    card_in = 0; tick();
    card_in = 1; tick(); tick();
    checks++;
    if (state_b !== 4'd0 || ret_b !== 1'b1 || done_b !== 1'b0) begin
      failures++; $display("FAIL retain_sticky: state=%0d ret=%0b done=%0b want 0/1/0", state_b, ret_b, done_b);
    end
    do_reset();
    checks++;
    if (ret_b !== 1'b0) begin failures++; $display("FAIL retain_reset: got %0b want 0", ret_b); end
  endtask

  task automatic test_timeout();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (state_b !== 4'd2) begin failures++; $display("FAIL timeout_early: got %0d want 2", state_b); end
    tick();
    checks++;
    if (state_b !== 4'd8 || err_b !== 3'd5) begin
      failures++; $display("FAIL timeout: state=%0d err=%0d want 8/5", state_b, err_b);
    end
    tick();
    checks++;
    if (ej_b !== 1'b1) begin failures++; $display("FAIL timeout_eject: got %0b want 1", ej_b); end
    end_card(0);
  endtask

  task automatic test_pin_last_cycle();
    do_reset();
    session_start(0);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (state_b !== 4'd1) begin failures++; $display("FAIL pin_wait: got %0d want 1", state_b); end
    enter_pin(0, PINC, 2, 0);
    op_valid = 1; op_code = 2'b11;
    tick();
    op_valid = 0;
    checks++;
    if (state_b !== 4'd8) begin failures++; $display("FAIL op_eject: got %0d want 8", state_b); end
    tick();
    end_card(0);
  endtask

  task automatic test_card_removal();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    op_valid = 1; op_code = 2'b10;
    tick();
    op_valid = 0;
    card_in = 0;
    tick();
    checks++;
    if (state_b !== 4'd8 || balance_b !== BIG0) begin
      failures++; $display("FAIL card_removed: state=%0d bal=%0d want 8/%0d", state_b, balance_b, BIG0);
    end
    tick();
    checks++;
    if (ej_b !== 1'b1 || state_b !== 4'd0) begin failures++; $display("FAIL removed_eject: ej=%0b state=%0d want 1/0", ej_b, state_b); end
  endtask

  task automatic test_reentry_gate();
    do_reset();
    session_start(0);
    enter_pin(0, PINC, 2, 0);
    op_valid = 1; op_code = 2'b11;
    tick();
    op_valid = 0;
    repeat (4) tick();
    checks++;
    if (state_b !== 4'd0) begin failures++; $display("FAIL reentry_held: got %0d want 0", state_b); end
    card_in = 0; tick();
    card_in = 1; tick();
    checks++;
    if (state_b !== 4'd1) begin failures++; $display("FAIL reentry_after_low: got %0d want 1", state_b); end
    end_card(0);
    tick();
  endtask

  task automatic test_random();
    int s, nops;
    logic [1:0]  op;
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      s = int'($urandom_range(0, 1));
      session_start(s);
      if ($urandom_range(0, 2) == 0) enter_pin(s, 4'b0110, 1, 1);
      enter_pin(s, PINC, 2, 0);
      nops = int'($urandom_range(1, 4));
      for (int j = 0; j < nops; j++) begin
        op = 2'($urandom_range(0, 2));
        case ($urandom_range(0, 5))
          0: a = 32'd0;
          1: a = 32'($urandom_range(1, 20000));
          2: a = 32'($urandom_range(1, 60000));
          3: a = $urandom();
          4: a = 32'hFFFF_FFFF - 32'(m_bal[s]) + 32'($urandom_range(0, 1));
          default: a = 32'(WDL) - 32'(m_sess[s]) + 32'($urandom_range(0, 1));
        endcase
        do_txn(s, op, a);
        finish_display(s, (j < nops - 1) ? 1'b1 : 1'b0);
      end
      end_card(s);
    end
  endtask

  initial begin
    test_reset();
    test_withdraw_basic();
    test_limit();
    test_insufficient();
    test_overflow();
    test_retain();
    test_timeout();
    test_pin_last_cycle();
    test_card_removal();
    test_reentry_gate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
- Parametrised next-generation ATM session controller.
- Accepts a card, verifies the PIN with an attempt limit and card retention, runs deposit, withdraw and balance-inquiry transactions against one registered balance, and enforces a per-session withdrawal limit.
- An inactivity timeout ejects the card.
- Sits between the keypad/card-reader front end and the display/dispenser back end.

Parameters:
BAL_W, 32, balance and amount width in bits
PIN_W, 4, PIN width in bits
INIT_BAL, 32'h000F4240, balance loaded at reset
PIN_CODE, 4'b1010, correct PIN
MAX_TRIES, 3, wrong PINs allowed before the card is retained (1..7)
WD_LIMIT, 32'd50000, maximum cumulative withdrawal per session
TIMEOUT, 1000, idle cycles allowed in a waiting state before forced eject

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
card_in  in  1  level, card present
pin_valid  in  1  pulse, pin is valid this cycle
pin  in  PIN_W  entered PIN
op_valid  in  1  pulse, op_code is valid this cycle
op_code  in  2  00 inquiry, 01 deposit, 10 withdraw, 11 eject
amt_valid  in  1  pulse, amount is valid this cycle
amount  in  BAL_W  transaction amount
another_op  in  1  sampled in DISPLAY: 1 returns to CHOOSE
balance  out  BAL_W  registered account balance
state  out  4  current state encoding
err_code  out  3  0 none, 1 bad PIN, 2 insufficient funds, 3 limit exceeded, 4 overflow, 5 timeout, 6 zero amount
card_eject  out  1  one-cycle pulse, card returned
card_retain  out  1  level, card swallowed; cleared only by reset
done  out  1  one-cycle pulse, session finished (eject or retain)

Behaviour:
- All state changes occur on the rising edge of clk. Reset is synchronous, active-high and sampled on the edge.
- Reset values: state=IDLE, balance=INIT_BAL, err_code=0, card_eject=0, card_retain=0, done=0; tries, session-withdrawn total and timer all 0.
- State encodings: IDLE=0, PIN=1, CHOOSE=2, DEPOSIT=3, WITHDRAW=4, CHECK=5, UPDATE=6, DISPLAY=7, EJECT=8, RETAIN=9.
- IDLE: on card_in=1, go to PIN; clear tries, session total and err_code.
- PIN, on pin_valid:
  - pin==PIN_CODE: go to CHOOSE, err_code=0.
  - Otherwise tries++ and err_code=1. If the new tries==MAX_TRIES, go to RETAIN; else stay in PIN.
- CHOOSE, on op_valid:
  - 00: go to DISPLAY.
  - 01: go to DEPOSIT.
  - 10: go to WITHDRAW.
  - 11: go to EJECT.
- DEPOSIT / WITHDRAW, on amt_valid: latch amount into an internal register and go to CHECK. amount==0 sets err_code=6 and goes to DISPLAY.
- CHECK (1 cycle):
  - Deposit: if balance+amt overflows BAL_W (carry out), err=4, go to DISPLAY; else go to UPDATE.
  - Withdraw: if amt>balance, err=2, go to DISPLAY. Else if session_total+amt>WD_LIMIT (computed at BAL_W+1 bits), err=3, go to DISPLAY. Else go to UPDATE.
  - When both the funds and limit conditions fail, insufficient funds (2) takes priority.
- UPDATE (1 cycle): balance ± amt; for a withdraw, session_total += amt; err=0; go to DISPLAY. balance is visible updated on the cycle after UPDATE.
- DISPLAY (1 cycle): another_op=1 goes to CHOOSE; else goes to EJECT.
- EJECT (1 cycle): card_eject=1, done=1, go to IDLE. IDLE is not re-entered toward PIN until card_in has been seen low for at least one cycle.
- RETAIN (1 cycle): card_retain=1 (sticky), done=1, go to IDLE. IDLE ignores card_in while card_retain=1.
- Timeout:
  - Timer counts in PIN, CHOOSE, DEPOSIT and WITHDRAW while no valid strobe is present.
  - It resets on any state change or valid strobe.
  - When the timer reaches TIMEOUT-1, the next state is EJECT with err=5. A valid strobe on the same cycle wins over the timeout.
- Card removal: card_in=0 in any state other than IDLE, EJECT or RETAIN aborts to EJECT. Balance is unchanged unless UPDATE has already completed.
- Simultaneous valid strobes: only the strobe relevant to the current state is used; all others are ignored.
- A reset mid-session restores INIT_BAL. There is no persistence.

Test Plan:
- Reset; card_in=1; pin=1010; op 10 with amount 40000; another_op=0 -> balance=960000, card_eject pulse, done pulse, err=0.
- Three pins of 0001 -> err=1 after each; RETAIN on the 3rd; card_retain=1; a later card_in is ignored until reset.
- Withdraw 30000, another_op=1, withdraw 30000 -> second gives err=3; balance=970000.
- With INIT_BAL=100, withdraw 200 -> err=2; balance unchanged at 100.
- Deposit 32'hFFFFFFFF at balance 1000000 -> err=4, no change; deposit 500 -> balance=1000500.
- Sit in CHOOSE for TIMEOUT cycles -> EJECT, err=5; pin_valid on the final cycle in PIN still transitions normally; dropping card_in in WITHDRAW -> EJECT.
